// File: rtl/ucsbece154a_pwrmgr_pkg.sv
// Shared state encodings for the power manager FSM.
// The 2-bit constants sit next to the controller's own state constants.
package ucsbece154a_pwrmgr_pkg;

  localparam logic [1:0] pm_state_active = 2'd0;
  localparam logic [1:0] pm_state_drain  = 2'd1;
  localparam logic [1:0] pm_state_sleep  = 2'd2;
  localparam logic [1:0] pm_state_wake   = 2'd3;

  typedef enum logic [1:0] {
    StActive = pm_state_active,
    StDrain  = pm_state_drain,
    StSleep  = pm_state_sleep,
    StWake   = pm_state_wake
  } pm_state_e;

endpackage

// File: rtl/ucsbece154a_pm_downcnt.sv
// Loadable down-counter that stops at zero, with zero/one flags.
// Used for the drain, wake-timer and wake-stabilisation counts.
module ucsbece154a_pm_downcnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o,
  output logic             one_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == Width'(1));

endmodule

// File: rtl/ucsbece154a_pwrmgr.sv
// Power manager: drains memory traffic, gates core enables while asleep and
// restores them after a stabilisation window once a wake source or timer fires.
module ucsbece154a_pwrmgr
  import ucsbece154a_pwrmgr_pkg::*;
#(
  parameter int unsigned TIMER_W      = 16,
  parameter int unsigned NUM_WAKE     = 4,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WAKE_CYCLES  = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sleep_req_i,
  input  logic [TIMER_W-1:0]  sleep_cycles_i,
  input  logic                mem_busy_i,
  input  logic [NUM_WAKE-1:0] wake_irq_i,
  input  logic [NUM_WAKE-1:0] wake_mask_i,
  output logic                core_en_o,
  output logic                sleeping_o,
  output logic                sleep_ack_o,
  output logic                wake_o,
  output logic [NUM_WAKE:0]   wake_cause_o,
  output logic [CNT_W-1:0]    slept_cycles_o
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned WakeW  = $clog2(WAKE_CYCLES + 1);

  pm_state_e            state_q, state_d;
  logic [TIMER_W-1:0]   sleep_cycles_q, sleep_cycles_d;
  logic [NUM_WAKE:0]    cause_q, cause_d;
  logic [CNT_W-1:0]     slept_q, slept_d;
  logic                 ack_q, ack_d;
  logic                 wake_q, wake_d;

  logic [NUM_WAKE-1:0]  ev_vec;
  logic                 ev;
  logic                 timer_hit;
  logic                 go_sleep, go_wake;
  logic                 drain_zero, drain_one;
  logic                 timer_zero, timer_one;
  logic                 wake_zero, wake_one;
  logic                 unused_flags;

  assign ev_vec    = wake_irq_i & wake_mask_i;
  assign ev        = |ev_vec;
  // A latched value of zero disables the timer wake entirely.
  assign timer_hit = (sleep_cycles_q != '0) && timer_one;

  ucsbece154a_pm_downcnt #(
    .Width (DrainW)
  ) u_drain_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     ((state_q == StActive) && sleep_req_i),
    .load_val_i (DrainW'(DRAIN_CYCLES - 1)),
    .en_i       (state_q == StDrain),
    .zero_o     (drain_zero),
    .one_o      (drain_one)
  );

  ucsbece154a_pm_downcnt #(
    .Width (TIMER_W)
  ) u_timer_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (go_sleep),
    .load_val_i (sleep_cycles_q),
    .en_i       (state_q == StSleep),
    .zero_o     (timer_zero),
    .one_o      (timer_one)
  );

  ucsbece154a_pm_downcnt #(
    .Width (WakeW)
  ) u_wake_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (go_wake),
    .load_val_i (WakeW'(WAKE_CYCLES - 1)),
    .en_i       (state_q == StWake),
    .zero_o     (wake_zero),
    .one_o      (wake_one)
  );

  assign unused_flags = drain_one ^ timer_zero ^ wake_one;

  always_comb begin
    state_d        = state_q;
    sleep_cycles_d = sleep_cycles_q;
    cause_d        = cause_q;
    slept_d        = slept_q;
    ack_d          = 1'b0;
    wake_d         = 1'b0;
    go_sleep       = 1'b0;
    go_wake        = 1'b0;
    unique case (state_q)
      StActive: begin
        if (sleep_req_i) begin
          sleep_cycles_d = sleep_cycles_i;
          cause_d        = '0;
          slept_d        = '0;
          state_d        = StDrain;
        end
      end
      StDrain: begin
        // A pending enabled level blocks sleep entirely.
        if (ev) begin
          cause_d = {1'b0, ev_vec};
          wake_d  = 1'b1;
          state_d = StActive;
        end else if (drain_zero && !mem_busy_i) begin
          ack_d    = 1'b1;
          go_sleep = 1'b1;
          state_d  = StSleep;
        end
      end
      StSleep: begin
        if (slept_q != '1) begin
          slept_d = slept_q + 1'b1;
        end
        if (ev || timer_hit) begin
          cause_d = cause_q | {timer_hit, ev_vec};
          go_wake = 1'b1;
          state_d = StWake;
        end
      end
      StWake: begin
        if (wake_zero) begin
          wake_d  = 1'b1;
          state_d = StActive;
        end
      end
      default: state_d = StActive;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StActive;
      sleep_cycles_q <= '0;
      cause_q        <= '0;
      slept_q        <= '0;
      ack_q          <= 1'b0;
      wake_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sleep_cycles_q <= sleep_cycles_d;
      cause_q        <= cause_d;
      slept_q        <= slept_d;
      ack_q          <= ack_d;
      wake_q         <= wake_d;
    end
  end

  assign sleeping_o     = (state_q == StSleep) || (state_q == StWake);
  assign core_en_o      = !sleeping_o;
  assign sleep_ack_o    = ack_q;
  assign wake_o         = wake_q;
  assign wake_cause_o   = cause_q;
  assign slept_cycles_o = slept_q;

endmodule

// File: tb/tb_ucsbece154a_pwrmgr.sv
// Scoreboard bench for the power manager: expected ack/wake events are queued
// when stimulus is driven and checked when the DUT pulses sleep_ack_o / wake_o.
module tb_ucsbece154a_pwrmgr;

  localparam int unsigned TimerW = 16;
  localparam int unsigned NumWake = 4;
  localparam int unsigned CntW = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sleep_req = 1'b0;
  logic [TimerW-1:0]  sleep_cycles = '0;
  logic               mem_busy = 1'b0;
  logic [NumWake-1:0] wake_irq = '0;
  logic [NumWake-1:0] wake_mask = '0;
  logic               core_en, sleeping, sleep_ack, wake;
  logic [NumWake:0]   wake_cause;
  logic [CntW-1:0]    slept_cycles;

  ucsbece154a_pwrmgr #(
    .TIMER_W      (TimerW),
    .NUM_WAKE     (NumWake),
    .DRAIN_CYCLES (2),
    .WAKE_CYCLES  (3),
    .CNT_W        (CntW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sleep_req_i    (sleep_req),
    .sleep_cycles_i (sleep_cycles),
    .mem_busy_i     (mem_busy),
    .wake_irq_i     (wake_irq),
    .wake_mask_i    (wake_mask),
    .core_en_o      (core_en),
    .sleeping_o     (sleeping),
    .sleep_ack_o    (sleep_ack),
    .wake_o         (wake),
    .wake_cause_o   (wake_cause),
    .slept_cycles_o (slept_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  bit started = 1'b0;

  int             q_kind[$];
  int             q_edge[$];
  logic [4:0]     q_cause[$];
  int             q_slept[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
  endtask

  // kind 0 = sleep_ack pulse, kind 1 = wake pulse; edge = posedge count it follows.
  task automatic sb_push(input int kind, input int edge_n, input logic [4:0] cause,
                         input int slept);
    q_kind.push_back(kind);
    q_edge.push_back(edge_n);
    q_cause.push_back(cause);
    q_slept.push_back(slept);
  endtask

  task automatic sb_pop(input int kind);
    int k, e, s;
    logic [4:0] c;
    if (q_kind.size() == 0) begin
      check_eq(kind == 1 ? "unexpected_wake" : "unexpected_ack", 64'(1), 64'(0));
    end else begin
      k = q_kind.pop_front();
      e = q_edge.pop_front();
      c = q_cause.pop_front();
      s = q_slept.pop_front();
      check_eq("event_kind", 64'(kind), 64'(k));
      check_eq(kind == 1 ? "wake_edge" : "ack_edge", 64'(cyc), 64'(e));
      if (k == 1) begin
        check_eq("wake_cause", 64'(wake_cause), 64'(c));
        check_eq("slept_cycles", 64'(slept_cycles), 64'(s));
        check_eq("core_en_at_wake", 64'(core_en), 64'(1));
      end else begin
        check_eq("core_en_at_ack", 64'(core_en), 64'(0));
      end
    end
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      if (sleep_ack) sb_pop(0);
      if (wake) sb_pop(1);
    end
  end

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Called at a negedge; returns the posedge index that samples the request.
  task automatic request(input int n, output int r);
    sleep_req = 1'b1;
    sleep_cycles = TimerW'(n);
    r = cyc + 1;
    @(negedge clk);
    sleep_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r, r2;
    logic [10:0] en_bits, slp_bits;
    logic [3:0]  abort_en;

    repeat (2) @(negedge clk);
    check_eq("rst_core_en", 64'(core_en), 64'(1));
    check_eq("rst_sleeping", 64'(sleeping), 64'(0));
    check_eq("rst_ack", 64'(sleep_ack), 64'(0));
    check_eq("rst_wake", 64'(wake), 64'(0));
    check_eq("rst_cause", 64'(wake_cause), 64'(0));
    check_eq("rst_slept", 64'(slept_cycles), 64'(0));
    reset = 1'b0;
    started = 1'b1;
    @(negedge clk);

    // Timer wake N=5: ack at r+2, core disabled for 8 cycles, wake at r+10.
    request(5, r);
    sb_push(0, r + 2, 5'b00000, 0);
    sb_push(1, r + 10, 5'b10000, 5);
    for (int i = 0; i <= 10; i++) begin
      wait_until(r + i);
      en_bits[i] = core_en;
      slp_bits[i] = sleeping;
    end
    check_eq("timer5_core_en_trace", 64'(en_bits), 64'(11'b10000000011));
    check_eq("timer5_sleeping_trace", 64'(slp_bits), 64'(11'b01111111100));
    wait_until(r + 11);

    // Shortest timer: one SLEEP cycle.
    request(1, r);
    sb_push(0, r + 2, 5'b00000, 0);
    sb_push(1, r + 6, 5'b10000, 1);
    wait_until(r + 7);

    // No timer; enabled source 2 sampled on the 40th SLEEP cycle.
    wake_mask = 4'b0100;
    request(0, r);
    sb_push(0, r + 2, 5'b00000, 0);
    wait_until(r + 30);
    check_eq("n0_still_sleeping", 64'(sleeping), 64'(1));
    wait_until(r + 41);
    wake_irq = 4'b0100;
    sb_push(1, r + 45, 5'b00100, 40);
    wait_until(r + 43);
    wake_irq = 4'b0000;
    wait_until(r + 46);

    // Pending enabled level aborts from DRAIN; core never disabled.
    wake_irq = 4'b0001;
    wake_mask = 4'b0001;
    request(7, r);
    sb_push(1, r + 1, 5'b00001, 0);
    for (int i = 0; i < 4; i++) begin
      wait_until(r + i);
      abort_en[i] = core_en;
    end
    check_eq("abort_core_en_trace", 64'(abort_en), 64'(4'b1111));
    wake_irq = 4'b0000;
    wait_until(r + 5);

    // Busy memory stretches DRAIN to 6 cycles; masked source and a second request ignored.
    wake_irq = 4'b1000;
    wake_mask = 4'b0000;
    mem_busy = 1'b1;
    request(4, r);
    sb_push(0, r + 6, 5'b00000, 0);
    sb_push(1, r + 13, 5'b10000, 4);
    wait_until(r + 5);
    check_eq("busy_drain_core_en", 64'(core_en), 64'(1));
    mem_busy = 1'b0;
    wait_until(r + 7);
    sleep_req = 1'b1;
    sleep_cycles = 16'd9;
    @(negedge clk);
    sleep_req = 1'b0;
    wait_until(r + 14);
    check_eq("busy_back_active", 64'(sleeping), 64'(0));
    wake_irq = 4'b0000;
    wait_until(r + 16);
    check_eq("second_req_ignored", 64'(sleeping), 64'(0));

    // Timer and enabled source fire on the same SLEEP cycle.
    wake_mask = 4'b0010;
    request(3, r);
    sb_push(0, r + 2, 5'b00000, 0);
    wait_until(r + 4);
    wake_irq = 4'b0010;
    sb_push(1, r + 8, 5'b10010, 3);
    wait_until(r + 6);
    wake_irq = 4'b0000;
    wait_until(r + 9);

    // Reset on the 20th SLEEP cycle of a 100-cycle timer.
    wake_mask = 4'b0000;
    request(100, r);
    sb_push(0, r + 2, 5'b00000, 0);
    wait_until(r + 21);
    check_eq("pre_reset_slept", 64'(slept_cycles), 64'(19));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_core_en", 64'(core_en), 64'(1));
    check_eq("mid_rst_sleeping", 64'(sleeping), 64'(0));
    check_eq("mid_rst_cause", 64'(wake_cause), 64'(0));
    check_eq("mid_rst_slept", 64'(slept_cycles), 64'(0));
    check_eq("mid_rst_ack", 64'(sleep_ack), 64'(0));
    @(negedge clk);

    // Fresh sequence after reset behaves normally.
    request(2, r2);
    sb_push(0, r2 + 2, 5'b00000, 0);
    sb_push(1, r2 + 7, 5'b10000, 2);
    wait_until(r2 + 8);

    for (int i = 0; i < 200 && q_kind.size() != 0; i++) @(negedge clk);
    check_eq("scoreboard_drained", 64'(q_kind.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
